// File: rtl/control_pipeline_elastic.sv
// rtl/control_pipeline_elastic.sv - elastic control-word pipeline with bubble collapse and flush
// Optional one-entry input skid register enabled by CTRL_PIPE_SKID_EN.
module control_pipeline_elastic #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          flush,
    output logic [$clog2(DEPTH+2)-1:0]    occupancy
);
    localparam int OW = $clog2(DEPTH+2);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] load;
    logic             drain;
    logic             all_full;
    logic             in_fire;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             prev_valid [DEPTH];
    logic [WIDTH-1:0] prev_data [DEPTH];
    logic [OW-1:0]    stage_cnt;

    assign drain = out_ready && !flush;

    // A stage can load whenever any stage at or after it is empty, or the tail drains.
    always_comb begin
        load     = '0;
        all_full = 1'b1;
        for (int i = DEPTH-1; i >= 0; i--) begin
            all_full = all_full && valid[i];
            load[i]  = !all_full || drain;
        end
    end

`ifdef CTRL_PIPE_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid_next;
    logic             ready_q;

    // in_ready comes from a flop, so out_ready never reaches it combinationally.
    assign in_ready        = ready_q && !flush;
    assign in_fire         = in_valid && in_ready;
    assign src_valid       = skid_valid || in_fire;
    assign src_data        = skid_valid ? skid_data : (in_fire ? in_data : '0);
    assign skid_valid_next = !flush && !load[0] && (skid_valid || in_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            ready_q    <= 1'b0;
        end else begin
            skid_valid <= skid_valid_next;
            ready_q    <= !skid_valid_next;
            if (!skid_valid_next)
                skid_data <= '0;
            else if (!skid_valid)
                skid_data <= in_data;
        end
    end

    assign occupancy = stage_cnt + OW'(skid_valid);
`else
    logic started;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            started <= 1'b0;
        else
            started <= 1'b1;
    end

    assign in_ready  = started && !flush && load[0];
    assign in_fire   = in_valid && in_ready;
    assign src_valid = in_fire;
    assign src_data  = in_fire ? in_data : '0;

    assign occupancy = stage_cnt;
`endif

    always_comb begin
        prev_valid[0] = src_valid;
        prev_data[0]  = src_data;
        for (int i = 1; i < DEPTH; i++) begin
            prev_valid[i] = valid[i-1];
            prev_data[i]  = data[i-1];
        end
    end

    // Invalid predecessors always carry 0, so a stage emptied by a shift reads as NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++)
                data[i] <= '0;
        end else if (flush) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++)
                data[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (load[i]) begin
                    valid[i] <= prev_valid[i];
                    data[i]  <= prev_valid[i] ? prev_data[i] : '0;
                end
            end
        end
    end

    always_comb begin
        stage_cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            stage_cnt = stage_cnt + OW'(valid[i]);
    end

    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];

endmodule
